// File: rtl/reg_file_pkg.sv
// Shared register-file constants used by decode, writeback and the register file itself.
package reg_file_pkg;

  localparam int REG_XLEN  = 32;  // data width of each architectural register
  localparam int REG_AW    = 5;   // register address width
  localparam int REG_NREGS = 32;  // number of architectural registers
  localparam int REG_ZERO  = 0;   // index of the hardwired-zero register

endpackage

// File: rtl/reg_file_register.sv
// Load-enable storage register with asynchronous active-high clear.
module reg_file_register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear immediately on rst; otherwise capture d when load is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file x0..x(NREGS-1): one synchronous write port, two
// combinational read ports, x0 hardwired to zero, optional write-to-read bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN   = REG_XLEN,
  parameter int NREGS  = REG_NREGS,
  parameter int AW     = REG_AW,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            reg_write,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] entries [NREGS];
  logic [AW-1:0]   rs_addr [2];
  logic [XLEN-1:0] rs_data [2];

  // Entry 0 has no storage; it always reads as zero.
  assign entries[0] = '0;

  // One storage register per non-zero entry; its load is the decoded one-hot
  // write enable. The x0 term is implicit because gi starts at 1.
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_entry
      reg_file_register #(
        .W(XLEN)
      ) u_register (
        .clk  (clk),
        .rst  (rst),
        .load (reg_write && (rd_addr == AW'(gi))),
        .d    (wr_data),
        .q    (entries[gi])
      );
    end
  endgenerate

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  // Two identical read ports: array lookup, then bypass, then the
  // zero overrides (x0 and reset) which take precedence over everything.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      logic [XLEN-1:0] port_data;

      // Combinational read with bypass and zero override.
      always_comb begin
        port_data = entries[rs_addr[gi]];
        if ((BYPASS != 0) && reg_write && (rd_addr != ZERO_ADDR) &&
            (rs_addr[gi] == rd_addr)) begin
          port_data = wr_data;
        end
        if (rst || (rs_addr[gi] == ZERO_ADDR)) begin
          port_data = '0;
        end
      end

      assign rs_data[gi] = port_data;
    end
  endgenerate

  assign rs1_data = rs_data[0];
  assign rs2_data = rs_data[1];

endmodule
